// File: rtl/posit_decode_arbiter.sv
// Two-requester arbiter sharing one combinational posit decoder, output registered behind valid/ready.
// Optional feature: define POSIT_DEC_RR_EN for round-robin arbitration (default: fixed priority to requester 0).

module decoder #(
  parameter int n  = 8,
  parameter int es = 1,
  parameter int rs = 4,
  parameter int fs = n-es-3
) (
  input  logic [n-1:0]  in,
  output logic          sign,
  output logic [rs-1:0] regi,
  output logic [es-1:0] expo,
  output logic [fs-1:0] frac,
  output logic          allone,
  output logic          allzero
);

  logic [n-2:0]     body;
  logic [rs-1:0]    run;
  logic             stop;
  logic [es+fs-1:0] rest;

  always_comb begin
    sign    = in[n-1];
    allzero = (in == '0);
    allone  = (in == {1'b1, {(n-1){1'b0}}});
    body    = in[n-1] ? (~in[n-2:0] + 1'b1) : in[n-2:0];
    run     = '0;
    stop    = 1'b0;
    for (int unsigned i = 0; i < n-1; i++) begin
      if (!stop && (body[n-2-i] == body[n-2])) run = run + rs'(1);
      else stop = 1'b1;
    end
    regi = body[n-2] ? (run - rs'(1)) : ('0 - run);
    // Bits after the regime run and its terminator, left-aligned into es+fs bits.
    rest = (es+fs)'(({body, {(es+fs){1'b0}}} << (run + rs'(1))) >> (n-1));
    expo = rest[es+fs-1 -: es];
    frac = rest[fs-1:0];
  end

endmodule

module posit_decode_arbiter #(
  parameter int n  = 8,
  parameter int es = 1,
  parameter int rs = 4,
  parameter int fs = n-es-3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [n-1:0]  in0,
  input  logic          in0_valid,
  output logic          in0_ready,
  input  logic [n-1:0]  in1,
  input  logic          in1_valid,
  output logic          in1_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_tag,
  output logic          sign,
  output logic [rs-1:0] regi,
  output logic [es-1:0] expo,
  output logic [fs-1:0] frac,
  output logic          allone,
  output logic          allzero
);

  localparam int DW = 1 + rs + es + fs + 2;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state_q, state_d;
  logic            tag_q, tag_d;
  logic [DW-1:0]   data_q, data_d;
  logic            pri_q;
  logic            load, grant0, grant1, accept;
  logic [n-1:0]    dec_in;
  logic            d_sign, d_allone, d_allzero;
  logic [rs-1:0]   d_regi;
  logic [es-1:0]   d_expo;
  logic [fs-1:0]   d_frac;

  decoder #(.n(n), .es(es), .rs(rs), .fs(fs)) u_dec (
    .in      (dec_in),
    .sign    (d_sign),
    .regi    (d_regi),
    .expo    (d_expo),
    .frac    (d_frac),
    .allone  (d_allone),
    .allzero (d_allzero)
  );

  always_comb begin
    load    = (state_q == EMPTY) | out_ready;
    grant0  = in0_valid & (~in1_valid | ~pri_q);
    grant1  = in1_valid & (~in0_valid | pri_q);
    accept  = load & (grant0 | grant1);
    dec_in  = grant1 ? in1 : in0;
    state_d = state_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (accept) begin
      state_d = FULL;
      tag_d   = grant1;
      data_d  = {d_sign, d_regi, d_expo, d_frac, d_allone, d_allzero};
    end else if (out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      tag_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

`ifdef POSIT_DEC_RR_EN
  logic pri_d;

  always_comb begin
    pri_d = pri_q;
    if (accept) pri_d = grant0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pri_q <= 1'b0;
    else     pri_q <= pri_d;
  end
`else
  assign pri_q = 1'b0;
`endif

  assign in0_ready = grant0 & load;
  assign in1_ready = grant1 & load;
  assign out_valid = (state_q == FULL);
  assign out_tag   = tag_q;
  assign {sign, regi, expo, frac, allone, allzero} = data_q;

endmodule

// File: tb/tb_posit_decode_arbiter.sv
// Self-checking bench for posit_decode_arbiter: directed steps then random traffic against a reference model.
module tb_posit_decode_arbiter;

  logic       clk, rst;
  logic [7:0] in0, in1;
  logic       in0_valid, in1_valid, in0_ready, in1_ready;
  logic       out_valid, out_ready, out_tag;
  logic       sign, allone, allzero;
  logic [3:0] regi;
  logic [0:0] expo;
  logic [3:0] frac;

  int checks = 0;
  int passed = 0;

  // Reference state
  logic        m_valid, m_tag, m_pri;
  logic [11:0] m_data;

  posit_decode_arbiter #(.n(8), .es(1), .rs(4), .fs(4)) dut (
    .clk(clk), .rst(rst),
    .in0(in0), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1(in1), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .sign(sign), .regi(regi), .expo(expo), .frac(frac),
    .allone(allone), .allzero(allzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posit fields from the number-format rules: {sign, regime k, exponent, fraction, NaR, zero}.
  function automatic logic [11:0] ref_dec(logic [7:0] w);
    int v, body, top, run, k, left, rest, f5;
    logic [31:0] kv;
    v = w;
    if (w[7]) v = (256 - v) % 256;
    body = v % 128;
    top  = body / 64;
    run  = 0;
    for (int b = 6; b >= 0; b--) begin
      if (((body >> b) & 1) == top) run++;
      else break;
    end
    k    = (top == 1) ? run - 1 : -run;
    left = 6 - run;
    if (left < 0) left = 0;
    rest = body % (1 << left);
    f5   = rest * (1 << (5 - left));
    kv   = k;
    return {w[7], kv[3:0], 1'(f5 / 16), 4'(f5 % 16), (w == 8'h80), (w == 8'h00)};
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_tag = 1'b0; m_pri = 1'b0; m_data = '0;
  endtask

  function automatic int winner();
    if (in0_valid && !in1_valid) return 0;
    if (in1_valid && !in0_valid) return 1;
    if (in0_valid && in1_valid) return m_pri ? 1 : 0;
    return -1;
  endfunction

  // One clock: check readies before the edge, advance model at the edge, check outputs after.
  task automatic cyc(string tag);
    int  w;
    logic free;
    #1;
    w    = winner();
    free = !m_valid || out_ready;
    chk({tag, ".in0_ready"}, 16'(in0_ready), 16'(free && w == 0));
    chk({tag, ".in1_ready"}, 16'(in1_ready), 16'(free && w == 1));
    @(posedge clk);
    if (free && w >= 0) begin
      m_valid = 1'b1;
      m_tag   = (w == 1);
      m_data  = ref_dec(w == 1 ? in1 : in0);
`ifdef POSIT_DEC_RR_EN
      m_pri   = (w == 0);
`endif
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk({tag, ".out_valid"}, 16'(out_valid), 16'(m_valid));
    chk({tag, ".out_tag"}, 16'(out_tag), 16'(m_tag));
    chk({tag, ".fields"}, 16'({sign, regi, expo, frac, allone, allzero}), 16'(m_data));
  endtask

  initial begin
    rst = 1'b1; in0 = '0; in1 = '0; in0_valid = 0; in1_valid = 0; out_ready = 0;
    model_reset();
    #12;
    chk("reset.out_valid", 16'(out_valid), 16'(0));
    chk("reset.fields", 16'({out_tag, sign, regi, expo, frac, allone, allzero}), 16'(0));
    rst = 1'b0;

    // Single requester
    in1 = 8'hC0; in1_valid = 1; out_ready = 1;
    cyc("single");
    chk("single.abs_tag", 16'(out_tag), 16'(1));
    chk("single.abs_sign", 16'(sign), 16'(1));
    in1_valid = 0;

    // Reset mid-stream
    in0 = 8'h40; in0_valid = 1; out_ready = 0;
    cyc("pre_rst");
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst.out_valid", 16'(out_valid), 16'(0));
    chk("midrst.fields", 16'({out_tag, sign, regi, expo, frac, allone, allzero}), 16'(0));
    #1 rst = 1'b0;

    // Contention: pri restarts at 0 after reset
    in0 = 8'h40; in1 = 8'h20; in0_valid = 1; in1_valid = 1; out_ready = 1;
    for (int i = 0; i < 4; i++) cyc("contend");

    // Backpressure with a word held
    in1_valid = 0; out_ready = 0; in0 = 8'h5A;
    for (int i = 0; i < 3; i++) cyc("stall");
    out_ready = 1;
    cyc("drain_accept");

    // Special words
    in0 = 8'h00; cyc("zero");
    chk("zero.allzero", 16'(allzero), 16'(1));
    in0 = 8'h80; cyc("nar");
    chk("nar.allone", 16'(allone), 16'(1));

    // Drain with no request
    in0 = 8'h37; cyc("last");
    in0_valid = 0;
    cyc("drain");
    cyc("idle");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in0       = 8'($urandom);
      in1       = 8'($urandom);
      in0_valid = 1'($urandom_range(0, 1));
      in1_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      cyc("rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/posit_decode_arbiter.md
# posit_decode_arbiter

Shares one combinational `decoder` instance between two independent posit-word requesters and registers its outputs behind a valid/ready handshake. Arbitrates each cycle between the two request ports and launches at most one word into the decoder. Captures sign/regi/expo/frac/allone/allzero plus a requester tag into a single output register. It sits between the operand-fetch front ends and the posit arithmetic datapath, so the decoder is instantiated once rather than per operand.

## Interface
- `n`, 8, posit word width; passed to `decoder`
- `es`, 1, exponent field width; passed to `decoder`
- `rs`, 4, regime field width; passed to `decoder`
- `fs`, n-es-3, fraction field width; passed to `decoder`
- `clk`  input  1  single clock; all state updates on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `in0`  input  n  requester 0 posit word
- `in0_valid`  input  1  requester 0 word present
- `in0_ready`  output  1  requester 0 word accepted this cycle when high together with `in0_valid`
- `in1`  input  n  requester 1 posit word
- `in1_valid`  input  1  requester 1 word present
- `in1_ready`  output  1  requester 1 accept
- `out_valid`  output  1  output register holds a decoded word
- `out_ready`  input  1  consumer takes the word
- `out_tag`  output  1  requester index (0/1) of the held word
- `sign`  output  1  registered decoder sign
- `regi`  output  rs  registered decoder regime
- `expo`  output  es  registered decoder exponent
- `frac`  output  fs  registered decoder fraction
- `allone`, `allzero`  output  1 each  registered decoder flags, unchanged from `decoder`

## Operation
- `load = !out_valid | out_ready`: the output register is free, or is being drained in the same cycle.
- Grant logic is combinational from `in0_valid`, `in1_valid` and the priority pointer `pri`:
  - Exactly one requester valid: that requester is granted.
  - Both valid: `pri` selects the winner.
  - Neither valid: no grant.
- `inX_ready = grantX & load`. The ready signals depend combinationally on both valids and `out_ready`. They never depend on the `in` data.
- The mux feeds the granted word (or `in0` when there is no grant) to the single `decoder`.
- Accepted cycle (`load` and a grant):
  - Output register ← decoder fields.
  - `out_tag` ← granted index.
  - `out_valid` ← 1.
- `out_ready` high with no accept: `out_valid` ← 0. Data fields hold their last value.
- `out_valid` high and `out_ready` low: all outputs hold, and both readies are 0 (backpressure).
- Pointer `pri` updates only on an accepted cycle. Its update rule depends on the configuration below.
- A requester must hold its word and valid until it sees ready. The block does not check this rule.

## Timing
- Latency: a word accepted at edge k appears on the outputs with `out_valid=1` immediately after edge k (1 cycle).
- Throughput: 1 word/cycle while `out_ready` stays high.
- Reset (async, any time, including mid-transfer):
  - `out_valid`, `out_tag`, `sign`, `regi`, `expo`, `frac`, `allone`, `allzero` all go to 0.
  - `pri` goes to 0 (requester 0 favoured).
  - A held word is discarded. A word in flight is not accepted.
- Simultaneous drain and accept in one cycle: the new word replaces the old one. There is no bubble.
- State machine, implicit in `out_valid`:
  - EMPTY→FULL on accept.
  - FULL→FULL on drain plus accept, or on stall.
  - FULL→EMPTY on drain without accept.

## Configuration
- `POSIT_DEC_RR_EN` defined: round-robin arbitration. After each accept, `pri` ← the index of the non-granted requester, so contending requesters alternate.
- `POSIT_DEC_RR_EN` undefined: fixed priority. `pri` is tied to 0 and requester 0 always wins contention. Requester 1 is served only when `in0_valid` is low.

## Test plan
- Reset mid-stream:
  - Stimulus: `in0=8'h40` valid and `out_valid=1`, then assert `rst` between edges.
  - Required response: all outputs read 0 without waiting for an edge, and `pri=0`.
- Single requester:
  - Stimulus: `in1=8'hC0`, `in1_valid=1`, `out_ready=1`.
  - Required response: `in1_ready=1`; one cycle later `out_valid=1`, `out_tag=1`, and the fields equal those of a standalone `decoder` driven with 8'hC0.
- Contention:
  - Stimulus: `in0=8'h40`, `in1=8'h20`, both valid for 4 cycles, `out_ready=1`.
  - Required response with RR: tags 0,1,0,1.
  - Required response without RR: tags 0,0,0,0, and `in1_ready` stays 0.
- Backpressure:
  - Stimulus: `out_ready=0` with a word held, and `in0` valid for 3 cycles.
  - Required response: `in0_ready=0` and the outputs are stable. On `out_ready=1`, the drain and the new accept happen in the same cycle.
- Special words:
  - Stimulus: `in0=8'h00`, then `8'h80`.
  - Required response: `allzero`/`allone` match a standalone `decoder` for each word, and `out_tag=0`.
- Drain with no request:
  - Stimulus: one accepted word, then both valids low and `out_ready=1`.
  - Required response: `out_valid` drops to 0 after one cycle, and the data fields hold their last value.
